// File: rtl/vga_line_prefetch.sv
// Double-buffered line prefetcher feeding the VGA timing controller with {r,g,b} pixels.
// Optional feature: define VGA_PREFETCH_UNDERRUN_EN to enable sticky underrun detection.
module vga_line_prefetch #(
    parameter int unsigned H_PIX    = 640,
    parameter int unsigned V_LINES  = 480,
    parameter int unsigned WORDS_LN = 160,
    parameter logic [16:0] FB_BASE  = 17'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  line,
    input  logic [9:0]  offset,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        fill_done,
    output logic        underrun
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  line_q;
    logic [8:0]  target_q, target_d;
    logic [7:0]  idx_q, idx_d;
    logic        disp_bank_q;
    logic        start_q;
    logic        lc;
    logic        wr_en;

    assign lc    = (line != line_q);
    assign wr_en = (state_q == REQ) && mem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            idx_q       <= '0;
            line_q      <= '0;
            disp_bank_q <= 1'b0;
            start_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            idx_q    <= idx_d;
            line_q   <= line;
            start_q  <= 1'b0;
            if (lc) begin
                disp_bank_q <= ~disp_bank_q;
            end
        end
    end

    // A line change always wins: it aborts any fetch and restarts at word 0.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        idx_d    = idx_q;
        if (lc) begin
            state_d  = REQ;
            idx_d    = '0;
            target_d = (line == 9'(V_LINES - 1)) ? '0 : line + 9'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_q) begin
                        state_d = REQ;
                        idx_d   = '0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (idx_q == 8'(WORDS_LN - 1)) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req   = (state_q == REQ);
        fill_done = (state_q == DONE);
        mem_addr  = FB_BASE + ({8'b0, target_q} << 7) + ({8'b0, target_q} << 5) + {9'b0, idx_q};
    end

    logic [15:0] ram_q [2][WORDS_LN];

    // Fill always targets the bank not on display at this edge, even if the bank swaps now.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[~disp_bank_q][idx_q] <= mem_rdata;
        end
    end

    logic        rd_hit;
    logic [15:0] rd_word_q;
    logic [1:0]  sel_q;
    logic        rd_valid_q;
    logic [2:0]  rgb_q;
    logic [3:0]  nib;
    logic        unused_nib_msb;

    assign rd_hit = (offset < 10'(H_PIX));

    always_ff @(posedge clk) begin
        if (rd_hit) begin
            rd_word_q <= ram_q[disp_bank_q][offset[9:2]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q      <= '0;
            rd_valid_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            sel_q      <= offset[1:0];
            rd_valid_q <= rd_hit;
            rgb_q      <= rd_valid_q ? nib[2:0] : '0;
        end
    end

    always_comb begin
        nib = rd_word_q[{sel_q, 2'b00} +: 4];
    end

    assign unused_nib_msb = nib[3];
    assign {r, g, b}      = rgb_q;

`ifdef VGA_PREFETCH_UNDERRUN_EN
    logic underrun_q;
    logic seen_lc_q;

    // The first line change after reset may legitimately interrupt the start-up fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
            seen_lc_q  <= 1'b0;
        end else if (lc) begin
            seen_lc_q <= 1'b1;
            if (seen_lc_q && (state_q != DONE)) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule
